// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: widths, ALU control
// encodings and the downstream control bundle carried into EX.
package id_ex_stage_pkg;

   localparam int unsigned DataWDefault = 32;
   localparam int unsigned RegAddrW     = 5;
   localparam int unsigned AluCtrlW     = 4;
   localparam int unsigned StallCntW    = 16;

   typedef enum logic [AluCtrlW-1:0] {
      AluAnd      = 4'b0000,
      AluOr       = 4'b0001,
      AluAdd      = 4'b0010,
      AluSub      = 4'b0110,
      AluSlt      = 4'b0111,
      AluNor      = 4'b1100,
      AluShiftLui = 4'b1111
   } alu_op_e;

   typedef struct packed {
      logic valid;
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
   } ex_ctrl_t;

   localparam ex_ctrl_t CtrlBubble = '0;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one EX operand: EX/MEM result, then MEM/WB data,
// otherwise the value read from the register file in ID.
module fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic [RegAddrW-1:0] src_addr_i,
   input  logic [DATA_W-1:0]   reg_data_i,
   input  logic                exm_regwrite_i,
   input  logic [RegAddrW-1:0] exm_rd_i,
   input  logic [DATA_W-1:0]   exm_result_i,
   input  logic                mwb_regwrite_i,
   input  logic [RegAddrW-1:0] mwb_rd_i,
   input  logic [DATA_W-1:0]   mwb_data_i,
   output logic [DATA_W-1:0]   data_o
);

   logic exm_hit;
   logic mwb_hit;

   // $0 is hardwired, so a writer targeting it never supplies a value
   assign exm_hit = exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == src_addr_i);
   assign mwb_hit = mwb_regwrite_i && (mwb_rd_i != '0) && (mwb_rd_i == src_addr_i);

   always_comb begin
      data_o = reg_data_i;
      if (exm_hit) begin
         data_o = exm_result_i;
      end else if (mwb_hit) begin
         data_o = mwb_data_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and two-level operand forwarding into the EX stage.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 id_valid_i,
   input  logic [DATA_W-1:0]    id_rs_data_i,
   input  logic [DATA_W-1:0]    id_rt_data_i,
   input  logic [DATA_W-1:0]    id_imm_i,
   input  logic [RegAddrW-1:0]  id_rs_addr_i,
   input  logic [RegAddrW-1:0]  id_rt_addr_i,
   input  logic [RegAddrW-1:0]  id_wr_addr_i,
   input  logic [AluCtrlW-1:0]  id_alu_ctrl_i,
   input  logic [4:0]           id_shamt_i,
   input  logic                 id_lui_i,
   input  logic                 id_sltiu_i,
   input  logic                 id_change_i,
   input  logic                 id_alusrc_i,
   input  logic                 id_regwrite_i,
   input  logic                 id_memread_i,
   input  logic                 id_memwrite_i,
   input  logic                 id_memtoreg_i,
   input  logic                 exm_regwrite_i,
   input  logic [RegAddrW-1:0]  exm_rd_i,
   input  logic [DATA_W-1:0]    exm_result_i,
   input  logic                 mwb_regwrite_i,
   input  logic [RegAddrW-1:0]  mwb_rd_i,
   input  logic [DATA_W-1:0]    mwb_data_i,
   input  logic                 flush_i,
   output logic                 stall_o,
   output logic                 ex_valid_o,
   output logic [DATA_W-1:0]    ex_src1_o,
   output logic [DATA_W-1:0]    ex_src2_o,
   output logic [DATA_W-1:0]    ex_store_o,
   output logic [AluCtrlW-1:0]  ex_ctrl_o,
   output logic [4:0]           ex_shamt_o,
   output logic                 ex_lui_o,
   output logic                 ex_sltiu_o,
   output logic                 ex_change_o,
   output logic [RegAddrW-1:0]  ex_wr_addr_o,
   output logic                 ex_regwrite_o,
   output logic                 ex_memread_o,
   output logic                 ex_memwrite_o,
   output logic                 ex_memtoreg_o,
   output logic [StallCntW-1:0] stall_cnt_o
);

   ex_ctrl_t               ctrl_q;
   logic [DATA_W-1:0]      rs_data_q, rt_data_q, imm_q;
   logic [RegAddrW-1:0]    rs_addr_q, rt_addr_q, wr_addr_q;
   logic [AluCtrlW-1:0]    alu_ctrl_q;
   logic [4:0]             shamt_q;
   logic                   lui_q, sltiu_q, change_q, alusrc_q;
   logic [StallCntW-1:0]   stall_cnt_q;
   logic [DATA_W-1:0]      fwd_rs, fwd_rt;
   logic                   load_use;
   logic                   load_bubble;

   assign load_use = ctrl_q.valid && ctrl_q.memread && (wr_addr_q != '0) && id_valid_i &&
                     ((wr_addr_q == id_rs_addr_i) || (wr_addr_q == id_rt_addr_i));
   assign load_bubble = load_use || flush_i || !id_valid_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i || load_bubble) begin
         ctrl_q     <= CtrlBubble;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rs_addr_q  <= '0;
         rt_addr_q  <= '0;
         wr_addr_q  <= '0;
         alu_ctrl_q <= '0;
         shamt_q    <= '0;
         lui_q      <= 1'b0;
         sltiu_q    <= 1'b0;
         change_q   <= 1'b0;
         alusrc_q   <= 1'b0;
      end else begin
         ctrl_q     <= '{valid:    1'b1,
                         regwrite: id_regwrite_i,
                         memread:  id_memread_i,
                         memwrite: id_memwrite_i,
                         memtoreg: id_memtoreg_i};
         rs_data_q  <= id_rs_data_i;
         rt_data_q  <= id_rt_data_i;
         imm_q      <= id_imm_i;
         rs_addr_q  <= id_rs_addr_i;
         rt_addr_q  <= id_rt_addr_i;
         wr_addr_q  <= id_wr_addr_i;
         alu_ctrl_q <= id_alu_ctrl_i;
         shamt_q    <= id_shamt_i;
         lui_q      <= id_lui_i;
         sltiu_q    <= id_sltiu_i;
         change_q   <= id_change_i;
         alusrc_q   <= id_alusrc_i;
      end
   end

   // Reset wins over a pending stall, so the stalled cycle is never counted
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
      end else if (load_use && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   fwd_mux #(
      .DATA_W (DATA_W)
   ) u_fwd_rs (
      .src_addr_i     (rs_addr_q),
      .reg_data_i     (rs_data_q),
      .exm_regwrite_i (exm_regwrite_i),
      .exm_rd_i       (exm_rd_i),
      .exm_result_i   (exm_result_i),
      .mwb_regwrite_i (mwb_regwrite_i),
      .mwb_rd_i       (mwb_rd_i),
      .mwb_data_i     (mwb_data_i),
      .data_o         (fwd_rs)
   );

   fwd_mux #(
      .DATA_W (DATA_W)
   ) u_fwd_rt (
      .src_addr_i     (rt_addr_q),
      .reg_data_i     (rt_data_q),
      .exm_regwrite_i (exm_regwrite_i),
      .exm_rd_i       (exm_rd_i),
      .exm_result_i   (exm_result_i),
      .mwb_regwrite_i (mwb_regwrite_i),
      .mwb_rd_i       (mwb_rd_i),
      .mwb_data_i     (mwb_data_i),
      .data_o         (fwd_rt)
   );

   assign stall_o       = load_use;
   assign ex_valid_o    = ctrl_q.valid;
   assign ex_src1_o     = fwd_rs;
   assign ex_src2_o     = alusrc_q ? imm_q : fwd_rt;
   assign ex_store_o    = fwd_rt;
   assign ex_ctrl_o     = alu_ctrl_q;
   assign ex_shamt_o    = shamt_q;
   assign ex_lui_o      = lui_q;
   assign ex_sltiu_o    = sltiu_q;
   assign ex_change_o   = change_q;
   assign ex_wr_addr_o  = wr_addr_q;
   assign ex_regwrite_o = ctrl_q.regwrite;
   assign ex_memread_o  = ctrl_q.memread;
   assign ex_memwrite_o = ctrl_q.memwrite;
   assign ex_memtoreg_o = ctrl_q.memtoreg;
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, forwarding priority,
// load-use stalls, flushes and the immediate operand path.
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   localparam int unsigned DW = 32;

   logic           clk = 1'b0;
   logic           rst_i;
   logic           id_valid_i;
   logic [DW-1:0]  id_rs_data_i, id_rt_data_i, id_imm_i;
   logic [4:0]     id_rs_addr_i, id_rt_addr_i, id_wr_addr_i;
   logic [3:0]     id_alu_ctrl_i;
   logic [4:0]     id_shamt_i;
   logic           id_lui_i, id_sltiu_i, id_change_i, id_alusrc_i;
   logic           id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
   logic           exm_regwrite_i;
   logic [4:0]     exm_rd_i;
   logic [DW-1:0]  exm_result_i;
   logic           mwb_regwrite_i;
   logic [4:0]     mwb_rd_i;
   logic [DW-1:0]  mwb_data_i;
   logic           flush_i;
   logic           stall_o, ex_valid_o;
   logic [DW-1:0]  ex_src1_o, ex_src2_o, ex_store_o;
   logic [3:0]     ex_ctrl_o;
   logic [4:0]     ex_shamt_o;
   logic           ex_lui_o, ex_sltiu_o, ex_change_o;
   logic [4:0]     ex_wr_addr_o;
   logic           ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o;
   logic [15:0]    stall_cnt_o;

   int n_vec = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   id_ex_stage #(
      .DATA_W (DW)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .id_valid_i     (id_valid_i),
      .id_rs_data_i   (id_rs_data_i),
      .id_rt_data_i   (id_rt_data_i),
      .id_imm_i       (id_imm_i),
      .id_rs_addr_i   (id_rs_addr_i),
      .id_rt_addr_i   (id_rt_addr_i),
      .id_wr_addr_i   (id_wr_addr_i),
      .id_alu_ctrl_i  (id_alu_ctrl_i),
      .id_shamt_i     (id_shamt_i),
      .id_lui_i       (id_lui_i),
      .id_sltiu_i     (id_sltiu_i),
      .id_change_i    (id_change_i),
      .id_alusrc_i    (id_alusrc_i),
      .id_regwrite_i  (id_regwrite_i),
      .id_memread_i   (id_memread_i),
      .id_memwrite_i  (id_memwrite_i),
      .id_memtoreg_i  (id_memtoreg_i),
      .exm_regwrite_i (exm_regwrite_i),
      .exm_rd_i       (exm_rd_i),
      .exm_result_i   (exm_result_i),
      .mwb_regwrite_i (mwb_regwrite_i),
      .mwb_rd_i       (mwb_rd_i),
      .mwb_data_i     (mwb_data_i),
      .flush_i        (flush_i),
      .stall_o        (stall_o),
      .ex_valid_o     (ex_valid_o),
      .ex_src1_o      (ex_src1_o),
      .ex_src2_o      (ex_src2_o),
      .ex_store_o     (ex_store_o),
      .ex_ctrl_o      (ex_ctrl_o),
      .ex_shamt_o     (ex_shamt_o),
      .ex_lui_o       (ex_lui_o),
      .ex_sltiu_o     (ex_sltiu_o),
      .ex_change_o    (ex_change_o),
      .ex_wr_addr_o   (ex_wr_addr_o),
      .ex_regwrite_o  (ex_regwrite_o),
      .ex_memread_o   (ex_memread_o),
      .ex_memwrite_o  (ex_memwrite_o),
      .ex_memtoreg_o  (ex_memtoreg_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1 ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_valid_i    = 1'b0;
      id_rs_data_i  = '0;
      id_rt_data_i  = '0;
      id_imm_i      = '0;
      id_rs_addr_i  = '0;
      id_rt_addr_i  = '0;
      id_wr_addr_i  = '0;
      id_alu_ctrl_i = '0;
      id_shamt_i    = '0;
      id_lui_i      = 1'b0;
      id_sltiu_i    = 1'b0;
      id_change_i   = 1'b0;
      id_alusrc_i   = 1'b0;
      id_regwrite_i = 1'b0;
      id_memread_i  = 1'b0;
      id_memwrite_i = 1'b0;
      id_memtoreg_i = 1'b0;
      flush_i       = 1'b0;
   endtask

   task automatic clear_fwd();
      exm_regwrite_i = 1'b0;
      exm_rd_i       = '0;
      exm_result_i   = '0;
      mwb_regwrite_i = 1'b0;
      mwb_rd_i       = '0;
      mwb_data_i     = '0;
   endtask

   task automatic set_add(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                          input logic [31:0] rtd, input logic [4:0] wr);
      clear_id();
      id_valid_i    = 1'b1;
      id_rs_addr_i  = rs;
      id_rs_data_i  = rsd;
      id_rt_addr_i  = rt;
      id_rt_data_i  = rtd;
      id_wr_addr_i  = wr;
      id_alu_ctrl_i = AluAdd;
      id_regwrite_i = 1'b1;
   endtask

   task automatic set_lw(input logic [4:0] wr);
      clear_id();
      id_valid_i    = 1'b1;
      id_rs_addr_i  = 5'd1;
      id_rt_addr_i  = wr;
      id_wr_addr_i  = wr;
      id_imm_i      = 32'd4;
      id_alusrc_i   = 1'b1;
      id_alu_ctrl_i = AluAdd;
      id_regwrite_i = 1'b1;
      id_memread_i  = 1'b1;
      id_memtoreg_i = 1'b1;
   endtask

   initial begin
      rst_i = 1'b0;
      clear_fwd();
      set_add(5'd3, 32'h5, 5'd7, 32'h9, 5'd8);

      // Reset holds a bubble even with a valid instruction presented
      tick();
      tick();
      check_eq("rst_valid", ex_valid_o, 0);
      check_eq("rst_src1", ex_src1_o, 0);
      check_eq("rst_src2", ex_src2_o, 0);
      check_eq("rst_wr", ex_wr_addr_o, 0);
      check_eq("rst_ctl", {ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o}, 0);
      check_eq("rst_cnt", stall_cnt_o, 0);
      check_eq("rst_stall", stall_o, 0);
      rst_i = 1'b1;

      // EX/MEM forward onto rs
      tick();
      check_eq("add_valid", ex_valid_o, 1);
      check_eq("add_src1_raw", ex_src1_o, 32'h5);
      check_eq("add_wr", ex_wr_addr_o, 8);
      check_eq("add_ctrl", ex_ctrl_o, AluAdd);
      exm_regwrite_i = 1'b1;
      exm_rd_i       = 5'd3;
      exm_result_i   = 32'h20;
      #1;
      check_eq("exm_src1", ex_src1_o, 32'h20);
      check_eq("exm_src2", ex_src2_o, 32'h9);

      // Forwarding priority on rt
      clear_fwd();
      set_add(5'd1, 32'hA, 5'd4, 32'h44, 5'd9);
      tick();
      exm_regwrite_i = 1'b1; exm_rd_i = 5'd4; exm_result_i = 32'h11;
      mwb_regwrite_i = 1'b1; mwb_rd_i = 5'd4; mwb_data_i = 32'h22;
      #1;
      check_eq("prio_src2", ex_src2_o, 32'h11);
      check_eq("prio_store", ex_store_o, 32'h11);
      exm_regwrite_i = 1'b0;
      #1;
      check_eq("mwb_src2", ex_src2_o, 32'h22);
      exm_regwrite_i = 1'b1; exm_rd_i = 5'd0; mwb_rd_i = 5'd0;
      #1;
      check_eq("rd0_src2", ex_src2_o, 32'h44);
      clear_fwd();

      // $0 register read is never forwarded
      set_add(5'd0, 32'h0, 5'd0, 32'h55, 5'd10);
      tick();
      exm_regwrite_i = 1'b1; exm_rd_i = 5'd0; exm_result_i = 32'hDEAD;
      #1;
      check_eq("r0_store", ex_store_o, 32'h55);
      clear_fwd();

      // Load-use: lw $2 then add using $2
      set_lw(5'd2);
      tick();
      check_eq("lw_memread", ex_memread_o, 1);
      set_add(5'd2, 32'h77, 5'd3, 32'h3, 5'd5);
      #1;
      check_eq("lu_stall", stall_o, 1);
      tick();
      check_eq("lu_bubble", ex_valid_o, 0);
      check_eq("lu_bubble_rw", ex_regwrite_o, 0);
      check_eq("lu_stall_gone", stall_o, 0);
      check_eq("lu_cnt", stall_cnt_o, 1);
      tick();
      check_eq("lu_add_valid", ex_valid_o, 1);
      check_eq("lu_add_wr", ex_wr_addr_o, 5);
      check_eq("lu_add_src1", ex_src1_o, 32'h77);
      check_eq("lu_cnt_hold", stall_cnt_o, 1);

      // A load to $0 never causes a stall
      set_lw(5'd0);
      tick();
      set_add(5'd0, 32'h0, 5'd0, 32'h0, 5'd6);
      #1;
      check_eq("lw0_nostall", stall_o, 0);

      // Flush squashes a store
      clear_id();
      id_valid_i = 1'b1; id_memwrite_i = 1'b1; id_rt_addr_i = 5'd7; id_alusrc_i = 1'b1;
      flush_i = 1'b1;
      tick();
      check_eq("fl_memwrite", ex_memwrite_o, 0);
      check_eq("fl_valid", ex_valid_o, 0);

      // Stall and flush together: one bubble, stall still raised
      set_lw(5'd6);
      tick();
      set_add(5'd6, 32'h1, 5'd1, 32'h1, 5'd7);
      flush_i = 1'b1;
      #1;
      check_eq("sf_stall", stall_o, 1);
      tick();
      check_eq("sf_bubble", ex_valid_o, 0);
      check_eq("sf_cnt", stall_cnt_o, 2);
      set_add(5'd1, 32'h1, 5'd1, 32'h1, 5'd11);
      tick();
      check_eq("sf_next_valid", ex_valid_o, 1);
      check_eq("sf_next_wr", ex_wr_addr_o, 11);

      // Immediate path with shift/lui control
      clear_id();
      id_valid_i    = 1'b1;
      id_alusrc_i   = 1'b1;
      id_imm_i      = 32'hFFFF_FFFC;
      id_alu_ctrl_i = AluShiftLui;
      id_lui_i      = 1'b1;
      id_change_i   = 1'b1;
      id_shamt_i    = 5'd5;
      id_rt_addr_i  = 5'd9;
      id_rt_data_i  = 32'h99;
      id_wr_addr_i  = 5'd9;
      id_regwrite_i = 1'b1;
      tick();
      mwb_regwrite_i = 1'b1; mwb_rd_i = 5'd9; mwb_data_i = 32'h1234;
      #1;
      check_eq("imm_src2", ex_src2_o, 32'hFFFF_FFFC);
      check_eq("imm_lui", ex_lui_o, 1);
      check_eq("imm_ctrl", ex_ctrl_o, 4'hF);
      check_eq("imm_store", ex_store_o, 32'h1234);
      check_eq("imm_shamt", ex_shamt_o, 5);
      check_eq("imm_change", ex_change_o, 1);
      check_eq("imm_sltiu", ex_sltiu_o, 0);
      clear_fwd();

      // Invalid ID slot loads a bubble
      clear_id();
      tick();
      check_eq("inv_valid", ex_valid_o, 0);

      // Reset arriving mid-stall clears the counter and the hazard
      set_lw(5'd2);
      tick();
      set_add(5'd2, 32'h1, 5'd0, 32'h0, 5'd3);
      #1;
      check_eq("rs_stall_pre", stall_o, 1);
      rst_i = 1'b0;
      tick();
      check_eq("rs_cnt", stall_cnt_o, 0);
      check_eq("rs_valid", ex_valid_o, 0);
      check_eq("rs_stall_post", stall_o, 0);
      rst_i = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
